blake512_nonce_scan: RTL and testbench

//  Sequencer for one blake512_hash core. Loads a 608-bit header, sweeps the 32-bit nonce over
//  [nonce_start..nonce_end], kicks the core once per nonce and compares each digest against a target.

---
 rtl/blake512_pkg.sv | 17 +
 rtl/blake512_nonce_scan_if.sv | 32 +++
 rtl/blake512_target_cmp.sv | 12 +
 rtl/blake512_nonce_scan.sv | 134 +++++++++++++
 tb/tb_blake512_nonce_scan.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/blake512_pkg.sv
// Shared types and widths for the BLAKE-512 nonce scanner.
package blake512_pkg;

  localparam int unsigned HDR_W    = 608;
  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned DATA_W   = HDR_W + NONCE_W;
  localparam int unsigned DIGEST_W = 512;

  typedef enum logic [2:0] {
    IDLE,
    KICK,
    WAIT,
    CHECK,
    DONE
  } scan_state_t;

endpackage

// File: rtl/blake512_nonce_scan_if.sv
// Host-side control/status bundle of the nonce scanner.
interface blake512_nonce_scan_if
  import blake512_pkg::*;
#(
  parameter int unsigned CMP_W = 64
) ();

  logic                  start;
  logic                  stop;
  logic [HDR_W-1:0]      header_in;
  logic [NONCE_W-1:0]    nonce_start;
  logic [NONCE_W-1:0]    nonce_end;
  logic [CMP_W-1:0]      target_in;
  logic                  busy;
  logic                  done;
  logic                  found;
  logic                  exhausted;
  logic [NONCE_W-1:0]    found_nonce;
  logic [DIGEST_W-1:0]   found_hash;
  logic [31:0]           hash_count;

  modport master (
    output start, stop, header_in, nonce_start, nonce_end, target_in,
    input  busy, done, found, exhausted, found_nonce, found_hash, hash_count
  );

  modport slave (
    input  start, stop, header_in, nonce_start, nonce_end, target_in,
    output busy, done, found, exhausted, found_nonce, found_hash, hash_count
  );

endinterface

// File: rtl/blake512_target_cmp.sv
// Unsigned digest-MSB <= target compare, shared with multi-core arbiters.
module blake512_target_cmp #(
  parameter int unsigned CMP_W = 64
) (
  input  logic [CMP_W-1:0] value,
  input  logic [CMP_W-1:0] target,
  output logic             le
);

  assign le = (value <= target);

endmodule

// File: rtl/blake512_nonce_scan.sv
// Sweeps the nonce over an inclusive range, kicking one hash core per nonce
// and stopping on the first digest whose MSBs do not exceed the target.
module blake512_nonce_scan
  import blake512_pkg::*;
#(
  parameter int unsigned HASH_CYCLES = 17,
  parameter int unsigned CMP_W       = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  blake512_nonce_scan_if.slave  host,
  output logic                  core_new,
  output logic [DATA_W-1:0]     core_data,
  input  logic [DIGEST_W-1:0]   core_hash
);

  localparam int unsigned WAIT_W = (HASH_CYCLES > 1) ? $clog2(HASH_CYCLES) : 1;

  scan_state_t          state, state_d;
  logic                 accept;
  logic                 hit;
  logic                 last;
  logic                 check_en;

  logic [HDR_W-1:0]     header_q;
  logic [NONCE_W-1:0]   nonce_q;
  logic [NONCE_W-1:0]   nonce_end_q;
  logic [CMP_W-1:0]     target_q;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 found_q;
  logic                 exhausted_q;
  logic [NONCE_W-1:0]   found_nonce_q;
  logic [DIGEST_W-1:0]  found_hash_q;
  logic [31:0]          hash_count_q;

  blake512_target_cmp #(.CMP_W(CMP_W)) u_cmp (
    .value  (core_hash[DIGEST_W-1 -: CMP_W]),
    .target (target_q),
    .le     (hit)
  );

  assign last     = (nonce_q == nonce_end_q);
  assign check_en = (state == CHECK) && !host.stop;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    core_new = 1'b0;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (host.start) begin
          accept  = 1'b1;
          state_d = KICK;
        end
      end
      KICK: begin
        core_new = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (wait_cnt == '0) state_d = CHECK;
      end
      CHECK: begin
        state_d = (hit || last) ? DONE : KICK;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort takes priority everywhere, including over a same-cycle start in IDLE.
    if (host.stop) begin
      state_d  = IDLE;
      core_new = 1'b0;
      accept   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      header_q      <= '0;
      nonce_q       <= '0;
      nonce_end_q   <= '0;
      target_q      <= '0;
      wait_cnt      <= '0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      hash_count_q  <= '0;
    end else begin
      if (accept) begin
        header_q     <= host.header_in;
        nonce_q      <= host.nonce_start;
        nonce_end_q  <= host.nonce_end;
        target_q     <= host.target_in;
        found_q      <= 1'b0;
        exhausted_q  <= 1'b0;
        hash_count_q <= '0;
      end
      if (state == KICK)
        wait_cnt <= WAIT_W'(HASH_CYCLES - 1);
      else if (state == WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - WAIT_W'(1);
      if (check_en) begin
        hash_count_q <= hash_count_q + 32'd1;
        if (hit) begin
          found_q       <= 1'b1;
          found_nonce_q <= nonce_q;
          found_hash_q  <= core_hash;
        end else if (last) begin
          exhausted_q <= 1'b1;
        end else begin
          nonce_q <= nonce_q + 32'd1;
        end
      end
    end
  end

  assign core_data        = {header_q, nonce_q};
  assign host.busy        = (state != IDLE);
  assign host.done        = (state == DONE);
  assign host.found       = found_q;
  assign host.exhausted   = exhausted_q;
  assign host.found_nonce = found_nonce_q;
  assign host.found_hash  = found_hash_q;
  assign host.hash_count  = hash_count_q;

endmodule

// File: tb/tb_blake512_nonce_scan.sv
// Randomised bench for blake512_nonce_scan with a stub core and a range-walk reference model.
module tb_blake512_nonce_scan;
  import blake512_pkg::*;

  localparam int unsigned HC  = 4;
  localparam int unsigned PER = HC + 2;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                core_new;
  logic [DATA_W-1:0]   core_data;
  logic [DIGEST_W-1:0] core_hash = '1;
  int                  stub_cnt  = 0;
  int                  cyc       = 0;
  int                  checks    = 0;
  int                  errors    = 0;

  logic [31:0]         kick_nonce[$];
  int                  kick_cyc[$];
  bit                  kick_hdr_ok[$];
  logic [HDR_W-1:0]    cur_hdr = '0;

  blake512_nonce_scan_if #(.CMP_W(64)) host_if ();

  blake512_nonce_scan #(.HASH_CYCLES(HC), .CMP_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .host      (host_if),
    .core_new  (core_new),
    .core_data (core_data),
    .core_hash (core_hash)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub core: garbage right after a kick, the replicated nonce exactly HC cycles later.
  always @(posedge clk) begin
    if (core_new) begin
      stub_cnt  <= HC;
      core_hash <= '1;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) core_hash <= {16{core_data[31:0]}};
    end
  end

  always @(negedge clk) begin
    if (core_new) begin
      kick_nonce.push_back(core_data[31:0]);
      kick_cyc.push_back(cyc);
      kick_hdr_ok.push_back(core_data[DATA_W-1:32] == cur_hdr);
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   host_if.busy,        '0);
    check({tag, "_done"},   host_if.done,        '0);
    check({tag, "_found"},  host_if.found,       '0);
    check({tag, "_exh"},    host_if.exhausted,   '0);
    check({tag, "_fnonce"}, host_if.found_nonce, '0);
    check({tag, "_fhash"},  host_if.found_hash,  '0);
    check({tag, "_count"},  host_if.hash_count,  '0);
    check({tag, "_new"},    core_new,            '0);
    check({tag, "_data"},   (core_data == '0),   1);
  endtask

  function automatic logic [HDR_W-1:0] rand_hdr();
    logic [HDR_W-1:0] h;
    for (int w = 0; w < 19; w++) h[w*32 +: 32] = $urandom();
    return h;
  endfunction

  task automatic run_scan(input string tag, input logic [HDR_W-1:0] hdr, input logic [31:0] ns,
                          input logic [31:0] ne, input logic [63:0] tgt, input bit poke);
    logic [31:0] exp_q[$];
    logic [31:0] n;
    bit          hit;
    int          c0, dones, done_at, limit;
    // Reference: walk the range in order, first nonce whose digest MSBs <= target wins.
    n   = ns;
    hit = 1'b0;
    forever begin
      exp_q.push_back(n);
      if ({n, n} <= tgt) begin hit = 1'b1; break; end
      if (n == ne) break;
      n = n + 32'd1;
    end
    @(negedge clk);
    host_if.header_in   = hdr;
    host_if.nonce_start = ns;
    host_if.nonce_end   = ne;
    host_if.target_in   = tgt;
    host_if.start       = 1'b1;
    cur_hdr = hdr;
    kick_nonce.delete(); kick_cyc.delete(); kick_hdr_ok.delete();
    c0 = cyc; dones = 0; done_at = -1;
    limit = PER * exp_q.size() + 6;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      host_if.start = 1'b0;
      if (poke && i == 2) begin
        host_if.start       = 1'b1;
        host_if.header_in   = ~hdr;
        host_if.nonce_start = ns + 32'd7;
        host_if.target_in   = '1;
      end
      if (host_if.done) begin dones++; done_at = cyc - c0; end
    end
    check({tag, "_dones"},   dones, 1);
    check({tag, "_done_at"}, done_at, 1 + PER * exp_q.size());
    check({tag, "_busy"},    host_if.busy, 0);
    check({tag, "_found"},   host_if.found, hit);
    check({tag, "_exh"},     host_if.exhausted, !hit);
    check({tag, "_count"},   host_if.hash_count, exp_q.size());
    if (hit) begin
      check({tag, "_fnonce"}, host_if.found_nonce, n);
      check({tag, "_fhash"},  host_if.found_hash, {16{n}});
    end
    check({tag, "_kicks"}, kick_nonce.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < kick_nonce.size(); i++) begin
      check($sformatf("%s_kick%0d_nonce", tag, i), kick_nonce[i], exp_q[i]);
      check($sformatf("%s_kick%0d_cyc", tag, i), kick_cyc[i] - c0, 1 + PER * i);
      check($sformatf("%s_kick%0d_hdr", tag, i), kick_hdr_ok[i], 1);
    end
  endtask

  initial begin
    logic [31:0] ns, ne, k;
    logic [63:0] tgt;
    int          len;
    int          dones;
    host_if.start = 1'b0; host_if.stop = 1'b0;
    host_if.header_in = '0; host_if.nonce_start = '0; host_if.nonce_end = '0; host_if.target_in = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    run_scan("hit_first", rand_hdr(), 32'd5, 32'd9, '1, 1'b0);
    run_scan("no_hit", rand_hdr(), 32'd10, 32'd13, '0, 1'b0);
    run_scan("wrap", rand_hdr(), 32'hFFFF_FFFE, 32'h0000_0001, '0, 1'b0);
    run_scan("tgt_c", rand_hdr(), 32'd10, 32'd20, 64'h0000_000C_0000_000C, 1'b0);
    run_scan("hit_mid", rand_hdr(), 32'hFFFF_FFFE, 32'h0000_0005, 64'h0000_0001_0000_0001, 1'b0);
    run_scan("hit_end", rand_hdr(), 32'hFFFF_FFFF, 32'h0000_0000, '0, 1'b0);
    run_scan("one", rand_hdr(), 32'h1234_5678, 32'h1234_5678, '0, 1'b0);
    run_scan("poke", rand_hdr(), 32'd40, 32'd43, '0, 1'b1);

    // Abort in the wait phase of the second nonce, then start+stop together in IDLE.
    @(negedge clk);
    host_if.header_in = rand_hdr(); host_if.nonce_start = 32'd100;
    host_if.nonce_end = 32'd110; host_if.target_in = '0; host_if.start = 1'b1;
    cur_hdr = host_if.header_in;
    kick_nonce.delete(); kick_cyc.delete(); kick_hdr_ok.delete();
    @(negedge clk);
    host_if.start = 1'b0;
    for (int i = 0; i < 40 && kick_nonce.size() < 2; i++) @(negedge clk);
    check("stop_kicks_before", kick_nonce.size(), 2);
    @(negedge clk);
    host_if.stop = 1'b1;
    @(negedge clk);
    host_if.stop = 1'b0;
    check("stop_busy", host_if.busy, 0);
    check("stop_new", core_new, 0);
    check("stop_count", host_if.hash_count, 1);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (host_if.done) dones++;
    end
    check("stop_dones", dones, 0);
    check("stop_found", host_if.found, 0);
    check("stop_exh", host_if.exhausted, 0);
    host_if.start = 1'b1; host_if.stop = 1'b1;
    @(negedge clk);
    host_if.start = 1'b0; host_if.stop = 1'b0;
    check("startstop_busy", host_if.busy, 0);
    repeat (8) @(negedge clk);
    check("startstop_kicks", kick_nonce.size(), 2);
    check("startstop_count", host_if.hash_count, 1);

    // Reset mid-scan after a hit so the sticky outputs are non-zero beforehand.
    run_scan("pre_rst", rand_hdr(), 32'd3, 32'd8, '1, 1'b0);
    @(negedge clk);
    host_if.header_in = rand_hdr(); host_if.nonce_start = 32'd0;
    host_if.nonce_end = 32'd40; host_if.target_in = '0; host_if.start = 1'b1;
    @(negedge clk);
    host_if.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    rst_n = 1'b1;

    for (int r = 0; r < 10; r++) begin
      ns  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : $urandom();
      len = $urandom_range(0, 5);
      ne  = ns + 32'(len);
      case ($urandom_range(0, 3))
        0:       tgt = '0;
        1:       tgt = '1;
        default: begin
          k   = ns + 32'($urandom_range(0, len));
          tgt = {k, k};
        end
      endcase
      run_scan($sformatf("rnd%0d", r), rand_hdr(), ns, ne, tgt, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
